reset_req_multi: RTL
====================

Name: reset_req_multi

Overview:
- Multi-source reset request aggregator and pulse extender.
- Synchronises N active-low reset request inputs and gates each with a per-channel enable. It raises one extended, registered reset request towards the SoC, holds it for a programmable number of clock-enable ticks after the last request releases, then enforces a hold-off window.
- Latches a sticky per-channel cause mask for the management registers.
- Sits between board-level reset sources (button, watchdog, PMIC, debug) and the SoC reset input.

Parameters:
CHANNELS, 4, number of reset request inputs (1..8)
CNT_WIDTH, 4, width of extend/hold-off counter
EXTEND_COUNT, 3, ce ticks the output stays asserted after all enabled requests release (0..2^CNT_WIDTH-1)
HOLDOFF_COUNT, 2, ce ticks after deassertion during which new requests are ignored (0 = no hold-off)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable tick for the extend/hold-off counters
reset_req_n  in  CHANNELS  asynchronous active-low request inputs
enable  in  CHANNELS  per-channel enable, synchronous to clk, 1 = channel may request reset
cause_clear  in  1  synchronous pulse, clears the cause mask
reset_req_out  out  1  registered active-high reset request
cause  out  CHANNELS  sticky mask of channels that triggered or held a request
busy  out  1  high in ASSERT or HOLDOFF

Behaviour:
- Reset (rst_n low, asynchronous): sync flops = all 1s; state = IDLE; counter = 0; reset_req_out = 0; cause = 0; busy = 0.
- Synchroniser: each reset_req_n bit passes through 2 flops (reset value 1). Define req[i] = ~sync[i] & enable[i] and any_req = |req.
- State machine, all transitions on clk:
  - IDLE: if any_req, go to ASSERT; reset_req_out <= 1; counter <= 0; cause <= cause | req.
  - ASSERT: reset_req_out stays 1; cause <= cause | req each cycle.
    - If any_req, counter <= 0.
    - Else if counter == EXTEND_COUNT, reset_req_out <= 0 and go to HOLDOFF with counter <= 0. If HOLDOFF_COUNT == 0, go to IDLE instead.
    - Else if ce, counter <= counter + 1.
  - HOLDOFF: requests ignored and cause not updated.
    - If counter == HOLDOFF_COUNT, go to IDLE.
    - Else if ce, counter <= counter + 1.
    - A request still active on return to IDLE re-triggers on the next cycle.
- Latency: raw input falling edge before clk edge 1 -> reset_req_out = 1 after edge 3.
- Release: sync high after edge k -> reset_req_out = 0 after edge k + (number of ce ticks to reach EXTEND_COUNT) + 1. With ce tied high this is edge k + EXTEND_COUNT + 1.
- EXTEND_COUNT = 0: output drops on the first cycle with no active request; minimum pulse is 1 clk.
- Counter never exceeds the compare value and never wraps.
- Enable dropped during ASSERT: that channel stops holding the request immediately. Its cause bit is retained.
- All enables low: no request is possible. An in-progress ASSERT completes its extension normally.
- cause_clear in the same cycle as a cause capture: capture wins. Bits set that cycle remain 1, other bits clear.
- Glitch shorter than one clk period may be missed. This is acceptable and there is no filtering requirement.
- busy = (state != IDLE), registered together with the state.
- rst_n asserted mid-operation returns all outputs to reset values immediately, without waiting for clk.

Test Plan:
- CHANNELS=4, EXTEND_COUNT=3, HOLDOFF_COUNT=2, ce=1, enable=4'hF. Pulse reset_req_n[1] low for 1 clk -> reset_req_out high 3 edges after assertion, low 4 edges after sync release; cause=4'b0010; busy high through the 2-tick hold-off.
- ce every 4th clk, hold channel 0 low 10 clks -> output stays high while low, then 3 ce ticks plus 1 clk after release; counter never exceeds 3.
- Channel 2 low with enable[2]=0 -> reset_req_out and cause stay 0. Set enable[2]=1 while it is still low -> assertion 1 clk later; cause=4'b0100.
- Channels 0 and 3 overlapping (3 releases last) -> single continuous assertion, extension timed from channel 3 release, cause=4'b1001. Then cause_clear -> cause=0.
- New request during HOLDOFF -> ignored, cause unchanged. Request still low at hold-off end -> re-assert 1 clk after return to IDLE. Also check cause_clear coinciding with a capture -> captured bit kept.
- rst_n low during ASSERT -> reset_req_out, busy, cause = 0 immediately. After release with all inputs high -> stays IDLE.

Source files
------------

// File: rtl/reset_req_multi.sv
// Multi-source reset request aggregator and pulse extender.
// Board-level active-low reset requests are synchronised and gated by a
// per-channel enable. Any active request raises one registered reset
// request towards the SoC. The request is held for EXTEND_COUNT ce ticks
// after the last request releases. A hold-off window follows, during which
// new requests are ignored. A sticky cause mask records which channels
// raised or held the request.
module reset_req_multi #(
   parameter int CHANNELS      = 4,
   parameter int CNT_WIDTH     = 4,
   parameter int EXTEND_COUNT  = 3,
   parameter int HOLDOFF_COUNT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ce,
   input  logic [CHANNELS-1:0] reset_req_n,
   input  logic [CHANNELS-1:0] enable,
   input  logic                cause_clear,
   output logic                reset_req_out,
   output logic [CHANNELS-1:0] cause,
   output logic                busy
);

   // State encoding. busy is the registered "state != IDLE" flag.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_HOLDOFF = 2'd2;

   localparam logic [CNT_WIDTH-1:0] EXT_CMP  = CNT_WIDTH'(EXTEND_COUNT);
   localparam logic [CNT_WIDTH-1:0] HOLD_CMP = CNT_WIDTH'(HOLDOFF_COUNT);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [CHANNELS-1:0]  sync1_q;
   logic [CHANNELS-1:0]  sync2_q;
   logic [CHANNELS-1:0]  req;
   logic                 any_req;

   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 out_d;
   logic [CHANNELS-1:0]  capture;
   logic [CHANNELS-1:0]  cause_d;

   // Two-flop synchroniser. It resets to "no request" (all ones).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= reset_req_n;
         sync2_q <= sync1_q;
      end
   end

   // The enable is applied after the synchroniser. Dropping an enable
   // therefore takes effect on the very next clock.
   assign req     = ~sync2_q & enable;
   assign any_req = |req;

   // Next-state, counter, output and cause-capture decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = reset_req_out;
      capture = '0;
      case (state_q)
         ST_IDLE: begin
            out_d = 1'b0;
            if (any_req) begin
               state_d = ST_ASSERT;
               out_d   = 1'b1;
               cnt_d   = '0;
               capture = req;
            end
         end
         ST_ASSERT: begin
            out_d   = 1'b1;
            capture = req;
            if (any_req) begin
               cnt_d = '0;
            end else if (cnt_q == EXT_CMP) begin
               out_d   = 1'b0;
               cnt_d   = '0;
               state_d = (HOLDOFF_COUNT == 0) ? ST_IDLE : ST_HOLDOFF;
            end else if (ce) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HOLDOFF: begin
            out_d = 1'b0;
            if (cnt_q == HOLD_CMP) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (ce) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
         end
      endcase
      // A capture in the same cycle as a clear wins for the captured bits.
      cause_d = (cause_clear ? '0 : cause) | capture;
   end

   // FSM, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         reset_req_out <= 1'b0;
         cause         <= '0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         reset_req_out <= out_d;
         cause         <= cause_d;
         busy          <= (state_d != ST_IDLE);
      end
   end

endmodule
